// File: rtl/fifo_burst_packer_pkg.sv
// Shared types and width helpers for the burst packer.
// State encoding plus in_count/out_len width derivation.
package fifo_burst_packer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  function automatic int cw_of(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int lw_of(input int blen);
    return $clog2(blen) + 1;
  endfunction

endpackage

// File: rtl/fifo_burst_packer.sv
// Packs beats from an upstream FIFO into framed bursts with first/last/len.
// Define BURST_TIMEOUT_EN to force partial bursts after TIMEOUT idle cycles.
module fifo_burst_packer
  import fifo_burst_packer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 256,
  parameter int BURST_LEN  = 16,
  parameter int TIMEOUT    = 64,
  localparam int CW = cw_of(FIFO_DEPTH),
  localparam int LW = lw_of(BURST_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CW-1:0]         in_count,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_first,
  output logic                  out_last,
  output logic [LW-1:0]         out_len,
  output logic                  busy
);

  state_t        r_state;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_acc;
  logic          r_flush_pend;

  logic w_rst;
  logic w_idle;
  logic w_accept;
  logic w_out_fire;
  logic w_full;
  logic w_part;
  logic w_tmo;
  logic w_start_part;
  logic w_pend_clr;

  assign w_rst      = rst | clear;
  assign w_idle     = (r_state == IDLE);
  assign w_accept   = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_full     = (in_count >= CW'(BURST_LEN));
  assign w_part     = (in_count != '0) && !w_full;

  assign w_start_part = w_idle && w_part && (r_flush_pend || w_tmo);
  assign w_pend_clr   = w_start_part || (w_idle && in_count == '0);

  assign in_ready = (r_state == BURST) && (r_acc < r_len)
                    && (!out_valid || out_ready);
  assign busy     = (r_state == BURST);

`ifdef BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] r_timer;

  assign w_tmo = w_idle && w_part && (r_timer == TW'(TIMEOUT - 1));

  // Counts only while a partial burst is waiting and nothing starts it.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_timer <= '0;
    end else if (w_idle && w_part && !w_start_part) begin
      r_timer <= r_timer + TW'(1);
    end else begin
      r_timer <= '0;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_acc        <= '0;
      r_flush_pend <= 1'b0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_first    <= 1'b0;
      out_last     <= 1'b0;
      out_len      <= '0;
    end else begin
      // A new flush outranks a same-cycle clear of the pending flag.
      r_flush_pend <= flush | (r_flush_pend & ~w_pend_clr);
      unique case (r_state)
        IDLE: begin
          if (w_full) begin
            r_state <= BURST;
            r_len   <= LW'(BURST_LEN);
            out_len <= LW'(BURST_LEN);
            r_acc   <= '0;
          end else if (w_start_part) begin
            r_state <= BURST;
            r_len   <= LW'(in_count);
            out_len <= LW'(in_count);
            r_acc   <= '0;
          end
        end
        BURST: begin
          if (w_accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            out_first <= (r_acc == '0);
            out_last  <= (r_acc == r_len - LW'(1));
            r_acc     <= r_acc + LW'(1);
          end else if (w_out_fire) begin
            out_valid <= 1'b0;
          end
          if (w_out_fire && out_last) begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_packer.sv
// Directed scoreboard bench for fifo_burst_packer (default parameters).
// Expected beats are queued on acceptance and compared on output handshake.
module tb_fifo_burst_packer;

  localparam int DW = 8;
  localparam int CW = 9;
  localparam int LW = 5;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_count = '0;
  logic          flush = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_first;
  logic          out_last;
  logic [LW-1:0] out_len;
  logic          busy;

  fifo_burst_packer dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_first (out_first),
    .out_last  (out_last),
    .out_len   (out_len),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    bit            f;
    bit            l;
    int            len;
  } exp_t;

  exp_t q[$];

  int n_chk = 0;
  int n_pass = 0;
  int sent, nbeats, base, k, exp_len, popped;
  int cyc = 0;
  int first_cyc, last_cyc;
  bit hold = 1'b0;
  logic [DW-1:0] hold_d;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input bit ordy, input bit fl);
    exp_t e;
    @(negedge clk);
    if (hold && out_valid) chk("hold_data", 32'(out_data), 32'(hold_d));
    out_ready = ordy;
    flush = fl;
    in_valid = (sent < nbeats);
    in_data = DW'(base + sent);
    #1;
    cyc++;
    if (in_valid && in_ready) begin
      q.push_back('{in_data, (k == 0), (k == exp_len - 1), exp_len});
      k++;
      sent++;
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("data", 32'(out_data), 32'(e.d));
        chk("first", 32'(out_first), 32'(e.f));
        chk("last", 32'(out_last), 32'(e.l));
        chk("len", 32'(out_len), 32'(e.len));
      end
      popped++;
      if (popped == 1) first_cyc = cyc;
      last_cyc = cyc;
    end
    hold = out_valid && !out_ready;
    hold_d = out_data;
    if (busy) in_count = '0;
  endtask

  task automatic setup(input int nb, input int elen, input int b);
    nbeats = nb;
    sent = 0;
    k = 0;
    exp_len = elen;
    popped = 0;
    base = b;
    hold = 1'b0;
    q.delete();
  endtask

  task automatic run_burst(input string tag, input int cnt, input bit fl,
                           input bit tog, input int nb, input int b);
    int i;
    setup(nb, nb, b);
    in_count = CW'(cnt);
    i = 0;
    while (popped < nb && i < 300) begin
      step(tog ? (i % 2 == 0) : 1'b1, fl && (i == 0));
      i++;
    end
    chk({tag, "_beats"}, 32'(popped), 32'(nb));
    chk({tag, "_sb_left"}, 32'(q.size()), 32'd0);
    if (!tog) chk({tag, "_consec"}, 32'(last_cyc - first_cyc), 32'(nb - 1));
    step(1'b1, 1'b0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int seen;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_len", 32'(out_len), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_first_last", 32'({out_first, out_last}), 32'd0);
    rst = 1'b0;
    setup(0, 0, 0);
    step(1'b1, 1'b0);

    run_burst("full16", 16, 1'b0, 1'b0, 16, 0);

    run_burst("flush5", 5, 1'b1, 1'b0, 5, 8'h20);
    setup(0, 0, 0);
    in_count = CW'(2);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      if (busy) seen++;
    end
    chk("flush_pend_cleared", 32'(seen), 32'd0);
    in_count = '0;
    step(1'b1, 1'b0);

    run_burst("toggle16", 16, 1'b0, 1'b1, 16, 8'h40);

    setup(16, 16, 8'h80);
    in_count = CW'(16);
    n = 0;
    while (popped < 7 && n < 100) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("clr_pre_beats", 32'(popped), 32'd7);
    @(negedge clk);
    clear = 1'b1;
    in_valid = 1'b0;
    sent = nbeats;
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    run_burst("after_clr", 16, 1'b0, 1'b0, 16, 8'hA0);

`ifdef BURST_TIMEOUT_EN
    setup(3, 3, 8'hC0);
    in_count = CW'(3);
    n = 0;
    while (!busy && n < 200) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("tmo_delay", 32'(n), 32'(TMO));
    n = 0;
    while (popped < 3 && n < 50) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("tmo_beats", 32'(popped), 32'd3);
    chk("tmo_sb_left", 32'(q.size()), 32'd0);
`else
    setup(0, 0, 0);
    in_count = CW'(3);
    seen = 0;
    for (int i = 0; i < TMO + 36; i++) begin
      step(1'b1, 1'b0);
      if (busy || out_valid) seen++;
    end
    chk("no_tmo_output", 32'(seen), 32'd0);
    in_count = '0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_burst_packer.md
FIFO_BURST_PACKER -- requirements
Module: fifo_burst_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of every data beat.
REQ-002 SHALL have parameter FIFO_DEPTH, default 256, depth of the upstream FIFO; CW = $clog2(FIFO_DEPTH)+1.
REQ-003 SHALL have parameter BURST_LEN, default 16, maximum beats per burst (power of 2, 2..FIFO_DEPTH); LW = $clog2(BURST_LEN)+1.
REQ-004 SHALL have parameter TIMEOUT, default 64, number of idle cycles before a partial burst is forced (>=2).
REQ-005 SHALL have clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have clear, input, 1, synchronous flush-to-idle with the same effect as rst.
REQ-008 SHALL have in_data, in_valid and in_ready (input DATA_WIDTH, input 1, output 1), valid-ready sink fed by the upstream FIFO output.
REQ-009 SHALL have in_count, input, CW, upstream FIFO occupancy.
REQ-010 SHALL have flush, input, 1, single-cycle request to emit all buffered data.
REQ-011 SHALL have out_data, out_valid and out_ready (output DATA_WIDTH, output 1, input 1), valid-ready source.
REQ-012 SHALL have out_first, out_last and out_len (output 1, 1, LW), giving the first and last beat of the burst and its beat count.
REQ-013 SHALL have busy, output, 1, high when not in IDLE.

Function
REQ-014 SHALL implement FSM states IDLE and BURST.
REQ-015 In IDLE with in_count>=BURST_LEN, SHALL enter BURST next cycle with len=BURST_LEN.
REQ-016 In IDLE with flush_pending and 0<in_count<BURST_LEN, SHALL enter BURST with len=in_count.
REQ-017 flush SHALL set flush_pending; flush_pending SHALL clear when a burst starts with len=in_count, or in IDLE with in_count==0; a flush pulse arriving in the same cycle as a clear event SHALL leave flush_pending set.
REQ-018 in_ready SHALL be (state==BURST) & (accepted<len) & (!out_valid | out_ready).
REQ-019 Each accepted beat SHALL be registered to out_data/out_valid in the next cycle, giving 1-cycle latency and full throughput.
REQ-020 out_first SHALL be high on beat index 0, out_last on beat index len-1, and out_len SHALL hold len for the whole burst.
REQ-021 out_data, out_first, out_last and out_len SHALL be held stable while out_valid & !out_ready.
REQ-022 BURST SHALL return to IDLE on the cycle after out_valid & out_ready & out_last; evaluation of the next burst starts from that IDLE cycle.
REQ-023 If in_valid is low mid-burst, SHALL stall without error; the burst length is never shortened.
REQ-024 in_count SHALL be sampled only in IDLE.

Reset
REQ-025 On rst or clear: state=IDLE, out_valid=0, out_first=0, out_last=0, out_len=0, out_data=0, in_ready=0, busy=0, flush_pending=0, timer=0, beat counters=0.
REQ-026 rst or clear mid-burst SHALL abandon the burst; the partially issued burst is not completed.

Configuration
REQ-027 Macro BURST_TIMEOUT_EN defined: a timer counts cycles in IDLE while 0<in_count<BURST_LEN; it resets on any other condition. At TIMEOUT-1 the block SHALL start a burst with len=in_count and reset the timer.
REQ-028 Macro BURST_TIMEOUT_EN undefined: no timer logic; partial bursts occur only via flush.

Structure
REQ-029 Package fifo_burst_packer_pkg SHALL hold the state enum (IDLE, BURST) and the LW/CW width helper functions.
REQ-030 A single module with no sub-module; the output holding register is inline.

Verification
REQ-031 in_count=16, 16 beats 0x00..0x0F, out_ready=1 -> one burst with first on 0x00, last on 0x0F, out_len=16, 16 consecutive valid cycles.
REQ-032 in_count=5 then flush pulse -> burst of 5 beats, out_len=5, last on the 5th beat, flush_pending cleared.
REQ-033 out_ready toggled 1/0 every cycle during a 16-beat burst -> data is held during stalls, no loss or duplication, order preserved.
REQ-034 BURST_TIMEOUT_EN, in_count=3 held idle -> burst of 3 starts TIMEOUT cycles later (64); without the macro -> no output.
REQ-035 clear asserted at beat 7 of 16 -> next cycle out_valid=0, busy=0, state IDLE; a later in_count=16 yields a fresh burst with out_first set.
